fifo_sync_v2: RTL and testbench

// Parametrised synchronous FIFO that replaces the single-mode SPI buffer in the TX and RX data paths.
// - Generalised width and depth.
// - Selectable read mode:
//   - first-word-fall-through (FWFT): head word visible without a read.
//   - standard: registered read data, 1-cycle latency.
// - Adds fill level, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.

---
 rtl/fifo_sync_v2_pkg.sv | 21 ++
 rtl/fifo_sync_v2_if.sv | 38 +++
 rtl/fifo_sync_v2_mem_2p.sv | 28 ++
 rtl/fifo_sync_v2.sv | 159 +++++++++++++++
 tb/tb_fifo_sync_v2.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_v2_pkg.sv
// Shared FIFO definitions: read-mode enum and level-width helper.
// The SPI TX/RX wrappers import this package as well.
package fifo_pkg;

    // Read-mode selector used by the FIFO and the SPI wrappers.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Width needed to count 0..depth entries inclusive.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Maps the integer FWFT parameter onto the mode enum.
    function automatic fifo_mode_e fifo_mode(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_sync_v2_if.sv
// Handshake/data bundle of fifo_sync_v2.
// The master side is the producer/consumer logic; the slave side is the FIFO.
interface fifo_sync_v2_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);

    localparam int LW = fifo_level_w(FIFO_DEPTH);

    logic                  clr_i;
    logic                  wr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic [LW-1:0]         level_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clr_i, wr_i, data_i, rd_i,
        input  data_o, valid_o, full_o, empty_o, level_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, data_i, rd_i,
        output data_o, valid_o, full_o, empty_o, level_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_sync_v2_mem_2p.sv
// Storage for fifo_sync_v2: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port: store the incoming word at the write pointer.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read feeds both the FWFT path and the registered read.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Parametrised synchronous FIFO with FWFT or registered read mode, a fill
// level, programmable almost flags and sticky overflow/underflow flags.
// Status outputs come from the registered level only, so wr_i/rd_i have
// no combinational path to them.
module fifo_sync_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 1,
    parameter int AFULL_THR  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THR = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    fifo_sync_v2_if.slave  bus
);

    localparam int         AW   = $clog2(FIFO_DEPTH);
    localparam int         LW   = fifo_level_w(FIFO_DEPTH);
    localparam fifo_mode_e MODE = fifo_mode(FWFT);

    // Reject depths the pointer arithmetic cannot handle.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_v2: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_v2: DATA_WIDTH must be >= 1");
    end

    logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]         level_reg,  level_next;
    logic                  ovf_reg,    ovf_next;
    logic                  udf_reg,    udf_next;

    logic                  empty;
    logic                  full;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LW'(FIFO_DEPTH));

    // A read needs a word; a write needs room, or a pop in the same cycle.
    assign rd_ok  = bus.rd_i & ~empty;
    assign wr_ok  = bus.wr_i & (~full | rd_ok);
    assign mem_we = wr_ok & ~bus.clr_i;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.data_i),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, level and sticky error flags; flush wins.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        ovf_next    = ovf_reg;
        udf_next    = udf_reg;
        if (bus.clr_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
            ovf_next    = 1'b0;
            udf_next    = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_next = level_reg + 1'b1;
                2'b01:   level_next = level_reg - 1'b1;
                default: level_next = level_reg;
            endcase
            if (bus.wr_i & ~wr_ok) begin
                ovf_next = 1'b1;
            end
            if (bus.rd_i & ~rd_ok) begin
                udf_next = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
            udf_reg    <= udf_next;
        end
    end

    assign bus.level_o        = level_reg;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_full_o  = (level_reg >= LW'(AFULL_THR));
    assign bus.almost_empty_o = (level_reg <= LW'(AEMPTY_THR));
    assign bus.overflow_o     = ovf_reg;
    assign bus.underflow_o    = udf_reg;

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word shown directly; masked to zero while empty so the
        // output never exposes stale (or uninitialised) storage.
        assign bus.data_o  = empty ? '0 : mem_rdata;
        assign bus.valid_o = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_reg,  data_next;
        logic                  valid_reg, valid_next;

        // Registered read: capture the head on a pop, pulse valid once.
        always_comb begin
            data_next  = data_reg;
            valid_next = 1'b0;
            if (bus.clr_i) begin
                data_next = '0;
            end else if (rd_ok) begin
                data_next  = mem_rdata;
                valid_next = 1'b1;
            end
        end

        // Read-data register; holds its word between pops.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                data_reg  <= data_next;
                valid_reg <= valid_next;
            end
        end

        assign bus.data_o  = data_reg;
        assign bus.valid_o = valid_reg;
    end

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed bench for fifo_sync_v2: one FWFT instance and one standard-read
// instance, both 8 x 8, sharing clock and reset.
module tb_fifo_sync_v2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fifo_sync_v2_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus_f ();
    fifo_sync_v2_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus_s ();

    fifo_sync_v2 #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(1)) u_dut_f (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_f)
    );

    fifo_sync_v2 #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) u_dut_s (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock on the FWFT instance: apply at a falling edge, return at the next.
    task automatic drv_f(input logic clr, input logic wr, input logic [7:0] d, input logic rd);
        bus_f.clr_i  = clr;
        bus_f.wr_i   = wr;
        bus_f.data_i = d;
        bus_f.rd_i   = rd;
        @(negedge clk_i);
        bus_f.clr_i = 1'b0;
        bus_f.wr_i  = 1'b0;
        bus_f.rd_i  = 1'b0;
        $display("txn fwft clr=%0b wr=%0b d=%02h rd=%0b -> level=%0d data_o=%02h valid=%0b",
                 clr, wr, d, rd, bus_f.level_o, bus_f.data_o, bus_f.valid_o);
    endtask

    // One clock on the standard-read instance.
    task automatic drv_s(input logic clr, input logic wr, input logic [7:0] d, input logic rd);
        bus_s.clr_i  = clr;
        bus_s.wr_i   = wr;
        bus_s.data_i = d;
        bus_s.rd_i   = rd;
        @(negedge clk_i);
        bus_s.clr_i = 1'b0;
        bus_s.wr_i  = 1'b0;
        bus_s.rd_i  = 1'b0;
        $display("txn std  clr=%0b wr=%0b d=%02h rd=%0b -> level=%0d data_o=%02h valid=%0b",
                 clr, wr, d, rd, bus_s.level_o, bus_s.data_o, bus_s.valid_o);
    endtask

    initial begin
        logic [7:0] exp_d;

        bus_f.clr_i = 1'b0; bus_f.wr_i = 1'b0; bus_f.rd_i = 1'b0; bus_f.data_i = '0;
        bus_s.clr_i = 1'b0; bus_s.wr_i = 1'b0; bus_s.rd_i = 1'b0; bus_s.data_i = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_f_level",  32'(bus_f.level_o), 0);
        chk("rst_f_empty",  32'(bus_f.empty_o), 1);
        chk("rst_f_full",   32'(bus_f.full_o), 0);
        chk("rst_f_ae",     32'(bus_f.almost_empty_o), 1);
        chk("rst_f_af",     32'(bus_f.almost_full_o), 0);
        chk("rst_f_data",   32'(bus_f.data_o), 0);
        chk("rst_f_valid",  32'(bus_f.valid_o), 0);
        chk("rst_f_ovf",    32'(bus_f.overflow_o), 0);
        chk("rst_f_udf",    32'(bus_f.underflow_o), 0);
        chk("rst_s_data",   32'(bus_s.data_o), 0);
        chk("rst_s_valid",  32'(bus_s.valid_o), 0);
        chk("rst_s_empty",  32'(bus_s.empty_o), 1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Fill to full; almost_full from level 7; 9th write dropped.
        for (int k = 1; k <= 8; k++) begin
            drv_f(1'b0, 1'b1, 8'(8'h11 * k), 1'b0);
            chk($sformatf("fill_level_%0d", k), 32'(bus_f.level_o), 32'(k));
            chk($sformatf("fill_af_%0d", k),    32'(bus_f.almost_full_o), (k >= 7) ? 1 : 0);
            chk($sformatf("fill_ae_%0d", k),    32'(bus_f.almost_empty_o), (k <= 1) ? 1 : 0);
        end
        chk("full_flag", 32'(bus_f.full_o), 1);
        chk("full_ovf0", 32'(bus_f.overflow_o), 0);
        drv_f(1'b0, 1'b1, 8'hEE, 1'b0);
        chk("ovf_level", 32'(bus_f.level_o), 8);
        chk("ovf_flag",  32'(bus_f.overflow_o), 1);
        chk("ovf_head",  32'(bus_f.data_o), 32'h11);

        // Flush clears the sticky overflow.
        drv_f(1'b1, 1'b0, 8'h00, 1'b0);
        chk("clr1_level", 32'(bus_f.level_o), 0);
        chk("clr1_ovf",   32'(bus_f.overflow_o), 0);
        chk("clr1_valid", 32'(bus_f.valid_o), 0);

        // Full with simultaneous write and read.
        for (int k = 1; k <= 8; k++) drv_f(1'b0, 1'b1, 8'(8'h11 * k), 1'b0);
        drv_f(1'b0, 1'b1, 8'h99, 1'b1);
        chk("fwr_level", 32'(bus_f.level_o), 8);
        chk("fwr_ovf",   32'(bus_f.overflow_o), 0);
        chk("fwr_full",  32'(bus_f.full_o), 1);
        for (int j = 0; j < 8; j++) begin
            exp_d = (j < 7) ? 8'(8'h11 * (j + 2)) : 8'h99;
            chk($sformatf("fwr_pop_%0d", j), 32'(bus_f.data_o), 32'(exp_d));
            drv_f(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("fwr_empty", 32'(bus_f.empty_o), 1);
        chk("fwr_valid", 32'(bus_f.valid_o), 0);

        // FWFT: word written into empty FIFO is visible after the write edge.
        drv_f(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_data",  32'(bus_f.data_o), 32'hA5);
        chk("fwft_valid", 32'(bus_f.valid_o), 1);
        drv_f(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_empty", 32'(bus_f.empty_o), 1);
        chk("fwft_vld0",  32'(bus_f.valid_o), 0);

        // Underflow: read alone on empty, then write+read on empty.
        drv_f(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_flag",  32'(bus_f.underflow_o), 1);
        chk("udf_level", 32'(bus_f.level_o), 0);
        drv_f(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("ewr_level", 32'(bus_f.level_o), 1);
        chk("ewr_udf",   32'(bus_f.underflow_o), 1);
        chk("ewr_data",  32'(bus_f.data_o), 32'h3C);
        chk("ewr_ovf",   32'(bus_f.overflow_o), 0);
        drv_f(1'b0, 1'b0, 8'h00, 1'b1);

        // 20 write/read pairs across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drv_f(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
            chk($sformatf("wrap_%0d", i), 32'(bus_f.data_o), 32'(8'h40 + i));
            drv_f(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("wrap_empty", 32'(bus_f.empty_o), 1);

        // Flush with a concurrent write at level 5.
        for (int i = 0; i < 5; i++) drv_f(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        chk("pre_clr_level", 32'(bus_f.level_o), 5);
        drv_f(1'b1, 1'b1, 8'h77, 1'b0);
        chk("clr_level", 32'(bus_f.level_o), 0);
        chk("clr_empty", 32'(bus_f.empty_o), 1);
        chk("clr_udf",   32'(bus_f.underflow_o), 0);
        chk("clr_ovf",   32'(bus_f.overflow_o), 0);
        chk("clr_ae",    32'(bus_f.almost_empty_o), 1);
        chk("clr_valid", 32'(bus_f.valid_o), 0);
        chk("clr_data",  32'(bus_f.data_o), 0);

        // Standard mode: registered read with one-cycle valid pulse.
        drv_s(1'b0, 1'b1, 8'h01, 1'b0);
        chk("std_ae1", 32'(bus_s.almost_empty_o), 1);
        drv_s(1'b0, 1'b1, 8'h02, 1'b0);
        chk("std_level2", 32'(bus_s.level_o), 2);
        chk("std_ae2",    32'(bus_s.almost_empty_o), 0);
        chk("std_vld_pre", 32'(bus_s.valid_o), 0);
        drv_s(1'b0, 1'b0, 8'h00, 1'b1);
        chk("std_rd_data",  32'(bus_s.data_o), 32'h01);
        chk("std_rd_valid", 32'(bus_s.valid_o), 1);
        drv_s(1'b0, 1'b0, 8'h00, 1'b0);
        chk("std_vld_drop", 32'(bus_s.valid_o), 0);
        chk("std_hold",     32'(bus_s.data_o), 32'h01);
        drv_s(1'b0, 1'b0, 8'h00, 1'b1);
        chk("std_rd2_data", 32'(bus_s.data_o), 32'h02);
        chk("std_rd2_lvl",  32'(bus_s.level_o), 0);
        drv_s(1'b0, 1'b0, 8'h00, 1'b1);
        chk("std_udf",      32'(bus_s.underflow_o), 1);
        chk("std_udf_vld",  32'(bus_s.valid_o), 0);
        chk("std_udf_data", 32'(bus_s.data_o), 32'h02);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) drv_f(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) drv_s(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        bus_f.wr_i = 1'b1; bus_f.data_i = 8'h6F;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_f_level", 32'(bus_f.level_o), 0);
        chk("arst_f_empty", 32'(bus_f.empty_o), 1);
        chk("arst_f_valid", 32'(bus_f.valid_o), 0);
        chk("arst_f_data",  32'(bus_f.data_o), 0);
        chk("arst_s_level", 32'(bus_s.level_o), 0);
        chk("arst_s_udf",   32'(bus_s.underflow_o), 0);
        chk("arst_s_data",  32'(bus_s.data_o), 0);
        chk("arst_s_af",    32'(bus_s.almost_full_o), 0);
        @(negedge clk_i);
        bus_f.wr_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_level", 32'(bus_f.level_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
